tm1638_frame_sched: RTL and testbench
=====================================

# tm1638_frame_sched

Frame scheduler for the TM1638 display path: decides when the display is rewritten and emits the exact command/data byte sequence to the downstream TM1638 byte-serial engine. The engine owns STB/CLK/DIO timing. Display refresh has three sources: host request, periodic refresh timer, and control (on/brightness) changes. The block arbitrates them into full frames or short control-only frames. It sits between the sensor/segment-encoding logic and the serial engine.

## Interface
- REFRESH_DIV, 1_000_000, clk cycles between automatic full refreshes (≥ 2)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- upd_req  in  1  one-cycle host request for a full frame
- seg_data  in  128  16 display bytes; byte k = seg_data[8k+7:8k], sent to address k
- disp_on  in  1  display enable
- bright  in  3  brightness level
- tx_valid  out  1  byte offered to engine
- tx_ready  in  1  engine accepts byte (transfer when tx_valid && tx_ready)
- tx_byte  out  8  byte value
- tx_last  out  1  last byte of a STB-low transaction; engine raises STB after it
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last byte of any frame transfers
- frame_cnt  out  8  completed full frames, wraps 255→0

## Operation
- Full frame, 19 bytes in 3 transactions:
  - 0x40, tx_last=1
  - 0xC0, then seg_data bytes 0..15; tx_last=1 on byte 15
  - 0x80 | disp_on<<3 | bright, tx_last=1
- Control frame: the control byte only, tx_last=1.
- States: IDLE → MODE → ADDR → DATA (16 bytes, 4-bit index) → CTRL → IDLE. The control frame uses IDLE → CTRL → IDLE.
- Pending flags:
  - pend_full is set by upd_req, by refresh timer expiry, and by reset release.
  - pend_ctrl is set when {disp_on,bright} differs from the last-sent control value.
- In IDLE:
  - pend_full wins and starts a full frame, clearing both flags, since a full frame carries the control byte.
  - Otherwise pend_ctrl starts a control frame.
- Events arriving during a frame set the flags. They never abort the current frame.
- seg_data and {disp_on,bright} are snapshotted in the cycle the frame starts. Later input changes do not affect that frame.
- The last-sent control value updates when the control byte transfers.
- The refresh timer counts regardless of busy.
  - On expiry it sets pend_full and reloads.
  - An upd_req-started frame does not reset the timer.
- frame_cnt increments only on completion of a full frame.

## Timing
- Reset values:
  - outputs: tx_valid=0, tx_byte=0, tx_last=0, busy=0, frame_done=0, frame_cnt=0
  - internal: timer=REFRESH_DIV-1, last-sent control=0, pend_ctrl=0, pend_full=1
- Outputs are registered.
- Start latency: with pend_full set in IDLE, busy and tx_valid rise 1 cycle after the flag; upd_req therefore leads to tx_valid 2 cycles later.
- Handshake:
  - tx_byte and tx_last are held stable while tx_valid && !tx_ready.
  - tx_valid is never dropped mid-frame without a transfer.
  - After a transfer, the next byte is presented on the following cycle with tx_valid kept high, so back-to-back transfers occur every cycle when tx_ready=1.
- Frame end: on the final transfer, tx_valid falls and frame_done pulses on the next cycle; busy falls in that same cycle.
- A new frame may start in the cycle after frame_done.
- Simultaneous events:
  - upd_req and timer expiry in the same cycle produce one pend_full.
  - upd_req in the frame_done cycle yields a new frame.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and tx_valid drops immediately. The engine must treat reset as a transaction abort.
- Timer width is $clog2(REFRESH_DIV).

## Structure
- Package tm1638_pkg:
  - CMD_DATA_AUTO=8'h40, CMD_ADDR0=8'hC0, CMD_CTRL_BASE=8'h80, NUM_GRIDS=16
  - state enum type
- Sub-module tm1638_refresh_tmr (parameter REFRESH_DIV; ports clk, rst, expire pulse).
- Frame sequencing FSM and arbitration live in the top module.

## Test plan
- Reset release, tx_ready=1, REFRESH_DIV=1000:
  - full frame 40, C0, seg bytes 0..15, 8F for disp_on=1 and bright=7
  - tx_last on byte indices 0, 17, 18
  - frame_done once, frame_cnt=1
- Backpressure: tx_ready toggles randomly → byte sequence identical to the previous test, tx_byte/tx_last never change while stalled.
- bright 7→2 while idle → single byte 0x8A with tx_last=1; frame_cnt unchanged.
- bright change and upd_req during a busy full frame → current frame finishes unchanged, then one full frame follows with control byte 0x8A; no separate control frame.
- seg_data changed mid-frame → current frame sends the old snapshot; no extra frame unless requested.
- Timer with REFRESH_DIV=50 and no requests → full frames start every 50 cycles; frame_cnt wraps 255→0 after 256 frames.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and helpers for the TM1638 frame scheduler.
package tm1638_pkg;

  localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0     = 8'hC0;
  localparam logic [7:0] CMD_CTRL_BASE = 8'h80;
  localparam int         NUM_GRIDS     = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MODE = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CTRL = 3'd4
  } state_e;

  // c = {disp_on, bright}
  function automatic logic [7:0] ctrl_byte(input logic [3:0] c);
    return CMD_CTRL_BASE | {4'h0, c};
  endfunction

endpackage

// File: rtl/tm1638_frame_sched_if.sv
// Byte handshake between the frame scheduler and the TM1638 serial engine.
interface tm1638_frame_sched_if;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       tx_last;

  modport master (
    output tx_valid,
    output tx_byte,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_byte,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/tm1638_refresh_tmr.sv
// Free-running refresh timer; expire is high for one cycle every REFRESH_DIV.
module tm1638_refresh_tmr #(
  parameter int REFRESH_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic expire
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0] LOAD = TW'(REFRESH_DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign expire = (cnt_q == '0);

  always_comb begin
    cnt_d = expire ? LOAD : cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= LOAD;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tm1638_frame_sched.sv
// Arbitrates host, timer and control-change refreshes into TM1638 byte frames.
module tm1638_frame_sched
  import tm1638_pkg::*;
#(
  parameter int REFRESH_DIV = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_req,
  input  logic [127:0]         seg_data,
  input  logic                 disp_on,
  input  logic [2:0]           bright,
  tm1638_frame_sched_if.master tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_GRIDS - 1);

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] seg_q, seg_d;
  logic [3:0]   snap_q, snap_d;
  logic [3:0]   sent_q, sent_d;
  logic         full_q, full_d;
  logic         pfull_q, pfull_d;
  logic         pctrl_q, pctrl_d;
  logic         valid_q, valid_d;
  logic [7:0]   byte_q, byte_d;
  logic         txl_q, txl_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [7:0]   cnt_q, cnt_d;

  logic       expire;
  logic       fire;
  logic [3:0] ctrl_in;
  logic [3:0] ctrl_ref;
  logic [3:0] nxt;

  tm1638_refresh_tmr #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .expire (expire)
  );

  assign fire    = valid_q & tx.tx_ready;
  assign ctrl_in = {disp_on, bright};
  assign nxt     = idx_q + 4'd1;
  // While a frame runs, its snapshot is what the display will end up with.
  assign ctrl_ref = busy_q ? snap_q : sent_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    snap_d  = snap_q;
    sent_d  = sent_q;
    full_d  = full_q;
    valid_d = valid_q;
    byte_d  = byte_q;
    txl_d   = txl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    pfull_d = pfull_q | upd_req | expire;
    pctrl_d = pctrl_q | (ctrl_in != ctrl_ref);
    unique case (state_q)
      ST_IDLE: begin
        if (pfull_q) begin
          state_d = ST_MODE;
          full_d  = 1'b1;
          seg_d   = seg_data;
          snap_d  = ctrl_in;
          valid_d = 1'b1;
          byte_d  = CMD_DATA_AUTO;
          txl_d   = 1'b1;
          busy_d  = 1'b1;
          pfull_d = upd_req | expire;
          pctrl_d = 1'b0;
        end else if (pctrl_q) begin
          state_d = ST_CTRL;
          full_d  = 1'b0;
          snap_d  = ctrl_in;
          valid_d = 1'b1;
          byte_d  = ctrl_byte(ctrl_in);
          txl_d   = 1'b1;
          busy_d  = 1'b1;
          pctrl_d = 1'b0;
        end
      end
      ST_MODE: begin
        if (fire) begin
          state_d = ST_ADDR;
          byte_d  = CMD_ADDR0;
          txl_d   = 1'b0;
        end
      end
      ST_ADDR: begin
        if (fire) begin
          state_d = ST_DATA;
          idx_d   = 4'd0;
          byte_d  = seg_q[7:0];
          txl_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_CTRL;
            byte_d  = ctrl_byte(snap_q);
            txl_d   = 1'b1;
          end else begin
            idx_d  = nxt;
            byte_d = seg_q[{nxt, 3'b000} +: 8];
            txl_d  = (nxt == LAST_IDX);
          end
        end
      end
      ST_CTRL: begin
        if (fire) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          txl_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sent_d  = snap_q;
          if (full_q) cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      seg_q   <= '0;
      snap_q  <= '0;
      sent_q  <= '0;
      full_q  <= 1'b0;
      pfull_q <= 1'b1;
      pctrl_q <= 1'b0;
      valid_q <= 1'b0;
      byte_q  <= '0;
      txl_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      snap_q  <= snap_d;
      sent_q  <= sent_d;
      full_q  <= full_d;
      pfull_q <= pfull_d;
      pctrl_q <= pctrl_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      txl_q   <= txl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset aborts the transaction: valid drops without waiting for the edge.
  assign tx.tx_valid = valid_q & rst;
  assign tx.tx_byte  = byte_q;
  assign tx.tx_last  = txl_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_tm1638_frame_sched.sv
// Directed bench for tm1638_frame_sched: byte tables, backpressure, timer wrap.
module tb_tm1638_frame_sched;
  import tm1638_pkg::*;

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rst2, upd_req, disp_on, rnd_en;
  logic [2:0]   bright;
  logic [127:0] seg, seg_a, seg_b;
  logic         busy, fdone, busy2, fdone2;
  logic [7:0]   fcnt, fcnt2;

  tm1638_frame_sched_if txif ();
  tm1638_frame_sched_if txif2 ();

  tm1638_frame_sched #(.REFRESH_DIV(1000)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .upd_req    (upd_req),
    .seg_data   (seg),
    .disp_on    (disp_on),
    .bright     (bright),
    .tx         (txif),
    .busy       (busy),
    .frame_done (fdone),
    .frame_cnt  (fcnt)
  );

  tm1638_frame_sched #(.REFRESH_DIV(50)) u_dut2 (
    .clk        (clk),
    .rst        (rst2),
    .upd_req    (1'b0),
    .seg_data   (seg_a),
    .disp_on    (1'b1),
    .bright     (3'd7),
    .tx         (txif2),
    .busy       (busy2),
    .frame_done (fdone2),
    .frame_cnt  (fcnt2)
  );

  assign txif2.tx_ready = 1'b1;

  initial begin
    txif.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      txif.tx_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the main DUT
  rec_t cap[$];
  int   done_cnt = 0, stall_n = 0, stall_viol = 0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pb = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (txif.tx_valid && txif.tx_ready)
        cap.push_back({txif.tx_byte, txif.tx_last});
      if (fdone) done_cnt <= done_cnt + 1;
      if (pv && !pr) begin
        stall_n <= stall_n + 1;
        if (!txif.tx_valid || txif.tx_byte !== pb || txif.tx_last !== pl)
          stall_viol <= stall_viol + 1;
      end
    end
    pv <= rst && txif.tx_valid;
    pr <= txif.tx_ready;
    pb <= txif.tx_byte;
    pl <= txif.tx_last;
  end

  // Monitor for the fast-timer DUT
  int cyc = 0, done2 = 0, last_start = -1, per_n = 0, per_bad = 0;
  logic       busy2_p = 1'b0;
  logic [7:0] c255 = 8'h00, c256 = 8'hFF;

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    busy2_p <= busy2;
    if (rst2) begin
      if (busy2 && !busy2_p) begin
        if (last_start >= 0) begin
          per_n <= per_n + 1;
          if (cyc - last_start != 50) per_bad <= per_bad + 1;
        end
        last_start <= cyc;
      end
      if (fdone2) begin
        done2 <= done2 + 1;
        if (done2 == 254) c255 <= fcnt2;
        if (done2 == 255) c256 <= fcnt2;
      end
    end
  end

  int   vecs = 0, errs = 0;
  rec_t tbl[$];
  rec_t r;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add_rec(input logic [7:0] b, input logic l);
    r.b = b;
    r.l = l;
    tbl.push_back(r);
  endtask

  task automatic add_full(input logic [127:0] s, input logic [7:0] c);
    add_rec(8'h40, 1'b1);
    add_rec(8'hC0, 1'b0);
    for (int k = 0; k < 16; k++) add_rec(s[8*k +: 8], k == 15);
    add_rec(c, 1'b1);
  endtask

  task automatic cmp_tbl(input string tag, input int base);
    chk({tag, "_len"}, 32'(cap.size() - base), 32'(tbl.size()));
    for (int i = 0; i < tbl.size(); i++)
      if (base + i < cap.size())
        chk($sformatf("%s[%0d]", tag, i), 32'(cap[base+i]), 32'(tbl[i]));
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic pulse_upd();
    @(posedge clk);
    #1 upd_req = 1'b1;
    @(posedge clk);
    #1 upd_req = 1'b0;
  endtask

  int base, dbase;

  initial begin
    rst = 1'b0; rst2 = 1'b0; upd_req = 1'b0; rnd_en = 1'b0;
    disp_on = 1'b1; bright = 3'd7;
    for (int k = 0; k < 16; k++) begin
      seg_a[8*k +: 8] = 8'hA0 + 8'(k);
      seg_b[8*k +: 8] = 8'h50 + 8'(k);
    end
    seg = seg_a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(txif.tx_valid), 0);
    chk("rst_byte",  32'(txif.tx_byte), 0);
    chk("rst_last",  32'(txif.tx_last), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(fdone), 0);
    chk("rst_cnt",   32'(fcnt), 0);

    // Reset release starts a full frame
    base = cap.size(); dbase = done_cnt;
    tbl.delete(); add_full(seg_a, 8'h8F);
    @(posedge clk); #1 rst = 1'b1;
    wait_done(dbase + 1, 60, "t1");
    repeat (5) @(negedge clk);
    #1;
    cmp_tbl("t1", base);
    chk("t1_ndone", 32'(done_cnt - dbase), 1);
    chk("t1_cnt", 32'(fcnt), 1);

    // Backpressure and request latency
    base = cap.size(); dbase = done_cnt;
    rnd_en = 1'b1;
    pulse_upd();
    @(negedge clk);
    chk("lat_c1", 32'(txif.tx_valid), 0);
    @(negedge clk);
    chk("lat_c2", 32'(txif.tx_valid), 1);
    wait_done(dbase + 1, 400, "t2");
    rnd_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    cmp_tbl("t2", base);
    chk("t2_stall_hold", 32'(stall_viol), 0);
    chk("t2_stalled", 32'(stall_n > 0), 1);
    chk("t2_cnt", 32'(fcnt), 2);

    // Brightness change while idle: control-only frame
    base = cap.size(); dbase = done_cnt;
    tbl.delete(); add_rec(8'h8A, 1'b1);
    @(posedge clk); #1 bright = 3'd2;
    wait_done(dbase + 1, 20, "t3");
    repeat (3) @(negedge clk);
    #1;
    cmp_tbl("t3", base);
    chk("t3_cnt", 32'(fcnt), 2);

    base = cap.size(); dbase = done_cnt;
    tbl.delete(); add_rec(8'h8F, 1'b1);
    @(posedge clk); #1 bright = 3'd7;
    wait_done(dbase + 1, 20, "t3b");
    repeat (3) @(negedge clk);
    #1;
    cmp_tbl("t3b", base);

    // Bright change plus request during a busy full frame
    base = cap.size(); dbase = done_cnt;
    tbl.delete(); add_full(seg_a, 8'h8F); add_full(seg_a, 8'h8A);
    pulse_upd();
    wait_busy("t4");
    @(posedge clk); #1 bright = 3'd2;
    pulse_upd();
    wait_done(dbase + 2, 120, "t4");
    repeat (15) @(negedge clk);
    #1;
    cmp_tbl("t4", base);
    chk("t4_ndone", 32'(done_cnt - dbase), 2);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_cnt", 32'(fcnt), 4);

    // seg_data changed mid-frame keeps the snapshot
    base = cap.size(); dbase = done_cnt;
    tbl.delete(); add_full(seg_a, 8'h8A);
    pulse_upd();
    wait_busy("t5");
    @(posedge clk); #1 seg = seg_b;
    wait_done(dbase + 1, 60, "t5");
    repeat (20) @(negedge clk);
    #1;
    cmp_tbl("t5", base);
    chk("t5_ndone", 32'(done_cnt - dbase), 1);

    base = cap.size(); dbase = done_cnt;
    tbl.delete(); add_full(seg_b, 8'h8A);
    pulse_upd();
    wait_done(dbase + 1, 60, "t5b");
    repeat (3) @(negedge clk);
    #1;
    cmp_tbl("t5b", base);
    chk("t5_cnt", 32'(fcnt), 6);

    // Reset mid-frame
    pulse_upd();
    wait_busy("t6");
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_now", 32'(txif.tx_valid), 0);
    @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cnt", 32'(fcnt), 0);
    chk("t6_byte", 32'(txif.tx_byte), 0);
    chk("t6_last", 32'(txif.tx_last), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Periodic refresh and frame_cnt wrap
    @(posedge clk); #1 rst2 = 1'b1;
    begin
      int n = 0;
      while (done2 < 256 && n < 256 * 50 + 300) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    chk("t7_done", 32'(done2 >= 256), 1);
    chk("t7_cnt255", 32'(c255), 255);
    chk("t7_wrap", 32'(c256), 0);
    chk("t7_nper", 32'(per_n), 255);
    chk("t7_period", 32'(per_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
